lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the core datapath's data-memory port.
- Takes the core's byte address, write data and funct3, and turns them into a word-addressed, byte-enabled request to data SRAM using a req/gnt/rvalid handshake.
- Aligns and extends load data back to the core.
- Raises stall so the core holds its PC until the access completes.

Parameters:
- WIDTH, 32, data width; only 32 supported.
- DADDR, 10, byte-address width from the core.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  core requests a memory access this instruction
- req_we  input  1  1 = store, 0 = load
- funct3  input  3  RISC-V access size/sign
- addr  input  DADDR  byte address (datapath ex_out)
- wdata  input  WIDTH  store data (rs2, unshifted)
- rdata  output  WIDTH  aligned, extended load result
- stall  output  1  core must hold PC and state
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle misalign/illegal pulse (with MISALIGN_TRAP_EN only)
- mem_req  output  1  memory request
- mem_we  output  1  memory write
- mem_addr  output  DADDR-2  word address
- mem_be  output  4  byte enables
- mem_wdata  output  WIDTH  lane-shifted store data
- mem_gnt  input  1  request accepted
- mem_rvalid  input  1  read data valid
- mem_rdata  input  WIDTH  read word

Behaviour:
- Reset is asynchronous on reset_n low. State goes to IDLE; rdata, done, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata all clear to 0.
- Reset mid-transaction abandons the transaction. Any later mem_gnt or mem_rvalid is ignored until the next request.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: when req_valid=1, register the aligned request (mem_addr=addr[DADDR-1:2], mem_be, shifted mem_wdata, mem_we=req_we, funct3, addr[1:0]) and go to REQ.
- REQ: hold mem_req=1 with stable fields until mem_gnt=1.
  - On grant of a store, go to DONE.
  - On grant of a load, go to WAIT.
  - mem_req drops in the cycle after the grant.
- WAIT: on mem_rvalid=1, capture the extended data into rdata and go to DONE.
  - mem_rvalid is earliest one cycle after mem_gnt. An rvalid seen in REQ is ignored.
- DONE: done=1 for exactly one cycle, then return to IDLE. A new request is accepted only from IDLE, so back-to-back accesses cost one bubble.
- stall = req_valid & ~done, combinational. stall is 0 when req_valid=0.
- req_valid, req_we, funct3, addr and wdata are stable from the request until done. Changes in between are ignored because the request is registered at acceptance.
- Byte enables:
  - byte: be = 0001 << addr[1:0]
  - half: be = 0011 << addr[1:0]
  - word: be = 1111
- Store data: wdata is replicated into the selected lanes (byte replicated x4, half replicated x2).
- Load extract uses lane addr[1:0]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- rdata holds its value until the next load completes. Stores do not change rdata.
- funct3 legal values: 000, 001, 010, plus 100 and 101 for loads only.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=00.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: an illegal funct3 or misaligned request in IDLE issues no memory access. The FSM goes directly to DONE, and err=1 together with done for one cycle. rdata is unchanged.
- Undefined: err is tied to 0. Misaligned addresses are force-aligned by clearing the offending low bits before lane select, and the access is performed. Illegal funct3 is treated as word.

Decomposition:
- lib_pkg: lsu_state_t enum (IDLE/REQ/WAIT/DONE), funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU, mem_size_t enum.
- Sub-module lsu_align: purely combinational. Inputs are size, offset and signedness; outputs are byte enables, store-data replication and load extract/extend.
- The lsu top holds the FSM and registers.

Test Plan:
1. SW, addr=0x104, wdata=0xDEADBEEF, mem_gnt after 2 cycles -> mem_addr=0x41, be=1111, mem_wdata=0xDEADBEEF; done 1 cycle after gnt; stall high until done.
2. SB, addr=0x013, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x04.
3. LB, addr=0x002, mem_rdata=0x12F03456, rvalid 1 cycle after gnt -> rdata=0xFFFFFFF0. LBU on the same word -> rdata=0x000000F0.
4. LH, addr=0x002, mem_rdata=0x80010000 -> rdata=0xFFFF8001. LHU -> rdata=0x00008001.
5. LH, addr=0x001:
   - With MISALIGN_TRAP_EN: no mem_req, done=err=1 for 1 cycle, rdata unchanged.
   - Without it: access at offset 0, be=0011.
6. reset_n low while in WAIT, then mem_rvalid pulses -> all outputs 0, state IDLE, rdata not updated; a following LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode for the load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
  endfunction

  // Illegal encodings fall back to a word access.
  function automatic mem_size_t f3_size(input logic [2:0] f3, input logic we);
    mem_size_t sz;
    sz = SZ_W;
    if (f3_legal(f3, we)) begin
      case (f3[1:0])
        2'b00:   sz = SZ_B;
        2'b01:   sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mem_size_t                    size,
  input  logic [1:0]                   off,
  input  logic                         sign,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [WIDTH-1:0]             rword,
  output logic [WIDTH/8-1:0]           be,
  output logic [WIDTH-1:0]             wrep,
  output logic [WIDTH-1:0]             rext
);
  localparam int NUM_LANES = WIDTH / 8;

  logic [7:0]  rb;
  logic [15:0] rh;

  // Halves are always lane-aligned here, so only off[1] picks the half.
  assign rb = rword[{off, 3'b000} +: 8];
  assign rh = rword[{off[1], 4'b0000} +: 16];

  always_comb begin
    be   = '1;
    wrep = wdata;
    rext = rword;
    case (size)
      SZ_B: begin
        be   = NUM_LANES'(1) << off;
        wrep = {NUM_LANES{wdata[7:0]}};
        rext = {{(WIDTH-8){sign & rb[7]}}, rb};
      end
      SZ_H: begin
        be   = NUM_LANES'(3) << off;
        wrep = {(NUM_LANES/2){wdata[15:0]}};
        rext = {{(WIDTH-16){sign & rh[15]}}, rh};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// Load/store unit: core byte access -> word SRAM req/gnt/rvalid transaction.
// Optional MISALIGN_TRAP_EN: misaligned/illegal requests complete with err, no access.
module lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DADDR = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       funct3,
  input  logic [DADDR-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic             done,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [DADDR-3:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);
  lsu_state_t state, state_n;
  mem_size_t  size_q, req_size, a_size;
  logic [1:0] off_q, req_off, a_off;
  logic       sign_q, a_sign, idle, trap;
  logic [3:0]       al_be;
  logic [WIDTH-1:0] al_wrep, al_rext;

  assign idle     = (state == IDLE);
  assign req_size = f3_size(funct3, req_we);

  // Lower bits that would misalign the access are dropped.
  always_comb begin
    req_off = 2'b00;
    case (req_size)
      SZ_B:    req_off = addr[1:0];
      SZ_H:    req_off = {addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = !f3_legal(funct3, req_we) ||
                ((req_size == SZ_H) && addr[0]) ||
                ((req_size == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // One aligner: live request fields while accepting, latched fields on load return.
  assign a_size = idle ? req_size   : size_q;
  assign a_off  = idle ? req_off    : off_q;
  assign a_sign = idle ? ~funct3[2] : sign_q;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .size  (a_size),
    .off   (a_off),
    .sign  (a_sign),
    .wdata (wdata),
    .rword (mem_rdata),
    .be    (al_be),
    .wrep  (al_wrep),
    .rext  (al_rext)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid)  state_n = trap ? DONE : REQ;
      REQ:     if (mem_gnt)    state_n = mem_we ? DONE : WAIT;
      WAIT:    if (mem_rvalid) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign mem_req = (state == REQ);
  assign done    = (state == DONE);
  assign stall   = req_valid & ~done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      size_q    <= SZ_W;
      off_q     <= 2'b00;
      sign_q    <= 1'b0;
      rdata     <= '0;
    end else begin
      state <= state_n;
      if (idle && req_valid && !trap) begin
        mem_we    <= req_we;
        mem_addr  <= addr[DADDR-1:2];
        mem_be    <= al_be;
        mem_wdata <= al_wrep;
        size_q    <= req_size;
        off_q     <= req_off;
        sign_q    <= ~funct3[2];
      end
      if ((state == WAIT) && mem_rvalid) rdata <= al_rext;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  // Set on the accepting edge, so it lines up with the single DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= idle & req_valid & trap;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-level memory model.
module tb_lsu;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, mem_wdata;
  logic        stall, done, err, mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu #(.WIDTH(32), .DADDR(10)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem_b [0:1023];
  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] get_word(input int w);
    return {mem_b[w*4+3], mem_b[w*4+2], mem_b[w*4+1], mem_b[w*4]};
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem_b[w*4+i] = v[8*i +: 8];
  endtask

  // Called just after a rising edge; returns just after the edge following done.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [9:0] a,
                           input logic [31:0] wd, input int gd, input int rd, input bit spur);
    int n, eoff, w, c, evt, gcnt, rcnt;
    bit legal, mis, trap, sgn, granted;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld;
    legal = (f3 inside {3'd0, 3'd1, 3'd2}) || (!we && (f3 inside {3'd4, 3'd5}));
    n     = !legal ? 4 : (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis   = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0);
    trap  = TRAP && (!legal || mis);
    eoff  = (int'(a[1:0]) / n) * n;
    w     = int'(a[9:2]);
    sgn   = !f3[2];
    ebe = '0;
    for (int i = 0; i < n; i++) ebe[eoff+i] = 1'b1;
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % n) +: 8];
    eld = '0;
    for (int i = 0; i < n; i++) eld[8*i +: 8] = mem_b[w*4+eoff+i];
    if (sgn && n < 4 && eld[8*n-1])
      for (int i = n; i < 4; i++) eld[8*i +: 8] = 8'hFF;

    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    gcnt = gd; rcnt = rd; granted = 1'b0; evt = -1; c = 0;
    while (c < 40) begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (done) break;
      chk("stall", stall, 1);
      if (mem_req && granted) begin
        chk("req_drop", mem_req, 0);
      end else if (mem_req) begin
        chk("mem_req", mem_req, !trap);
        chk("mem_addr", mem_addr, w);
        chk("mem_be", mem_be, ebe);
        chk("mem_we", mem_we, we);
        if (we) chk("mem_wdata", mem_wdata, ewd);
        if (gcnt == 0) begin mem_gnt = 1'b1; granted = 1'b1; if (we) evt = c; end
        else gcnt--;
        if (spur && $urandom_range(0, 1) == 1) begin mem_rvalid = 1'b1; mem_rdata = $urandom; end
      end else if (granted && !we) begin
        if (rcnt == 0) begin mem_rvalid = 1'b1; mem_rdata = get_word(w); evt = c; end
        else rcnt--;
      end
      c++;
    end
    chk("done", done, 1);
    chk("done_lat", c - evt, 1);
    chk("err", err, trap);
    chk("stall_done", stall, 0);
    chk("mem_req_done", mem_req, 0);
    if (!trap) begin
      if (we) for (int i = 0; i < n; i++) mem_b[w*4+eoff+i] = wd[8*i +: 8];
      else exp_rdata = eld;
    end
    chk("rdata", rdata, exp_rdata);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("err_pulse", err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [2:0] f3s [5];
    logic [2:0] f3;
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 0);     chk("rst_done", done, 0);
    chk("rst_err", err, 0);         chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);   chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);   chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stall", stall, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the access-size/lane rules.
    do_access(1'b1, 3'd2, 10'h104, 32'hDEADBEEF, 2, 0, 1'b0);
    do_access(1'b0, 3'd2, 10'h104, 32'h0, 0, 0, 1'b0);
    chk("sw_readback", rdata, 32'hDEADBEEF);
    do_access(1'b1, 3'd0, 10'h013, 32'h000000A5, 0, 0, 1'b0);
    do_access(1'b0, 3'd2, 10'h010, 32'h0, 1, 1, 1'b0);
    chk("sb_lane3", {24'h0, rdata[31:24]}, 32'hA5);
    set_word(0, 32'h12F03456);
    do_access(1'b0, 3'd0, 10'h002, 32'h0, 0, 0, 1'b0);
    chk("lb", rdata, 32'hFFFFFFF0);
    do_access(1'b0, 3'd4, 10'h002, 32'h0, 1, 0, 1'b0);
    chk("lbu", rdata, 32'h000000F0);
    set_word(0, 32'h80010000);
    do_access(1'b0, 3'd1, 10'h002, 32'h0, 0, 0, 1'b0);
    chk("lh", rdata, 32'hFFFF8001);
    do_access(1'b0, 3'd5, 10'h002, 32'h0, 0, 2, 1'b0);
    chk("lhu", rdata, 32'h00008001);
    do_access(1'b0, 3'd1, 10'h001, 32'h0, 0, 0, 1'b0);
    chk("lh_mis", rdata, TRAP ? 32'h00008001 : 32'h0);

    // Reset while waiting for read data; late responses must be ignored.
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd2; addr = 10'h008;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_req) break;
    end
    chk("rst6_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst6_rdata", rdata, 0);   chk("rst6_mem_req", mem_req, 0);
    chk("rst6_done", done, 0);     chk("rst6_mem_be", mem_be, 0);
    chk("rst6_mem_addr", mem_addr, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_rdata = '0;
    chk("rst6_ignored", rdata, 0);
    chk("rst6_idle_done", done, 0);
    chk("rst6_idle_req", mem_req, 0);
    do_access(1'b0, 3'd2, 10'h008, 32'h0, 1, 1, 1'b0);

    // Random mix, including illegal funct3 and misaligned addresses.
    repeat (300) begin
      if ($urandom_range(0, 9) < 8) f3 = f3s[$urandom_range(0, 4)];
      else f3 = 3'($urandom);
      do_access(1'($urandom), f3, 10'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
